// File: rtl/mem_access_unit_if.sv
// Request/response and memory-bus bundle for mem_access_unit.
// master = datapath/control unit plus Memory model; slave = mem_access_unit.
interface mem_access_unit_if;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        ls_req;
    logic        ls_write;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        fetch_done;
    logic        ls_done;
    logic        access_err;
    logic [31:0] instr_reg;
    logic [31:0] load_data;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output fetch_req, fetch_pc, ls_req, ls_write, ls_addr, ls_wdata, mem_rdata,
        input  fetch_done, ls_done, access_err, instr_reg, load_data, busy,
               mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  fetch_req, fetch_pc, ls_req, ls_write, ls_addr, ls_wdata, mem_rdata,
        output fetch_done, ls_done, access_err, instr_reg, load_data, busy,
               mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle IDLE/ACCESS/DONE controller in front of a unified memory, with IR/MDR capture.
// Optional macro MEM_ALIGN_CHECK_EN: faults fetches whose address is not word aligned.
module mem_access_unit #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned MEM_DEPTH   = 513
) (
    input  logic              Clk,
    input  logic              Reset_n,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        fetch_q, fetch_d;
    logic        fault_q, fault_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;

    logic ls_fault;
    logic fetch_fault;

    // Faults are decided at acceptance so ACCESS only needs one flag.
    assign ls_fault = (bus.ls_addr >= 32'(MEM_DEPTH));
`ifdef MEM_ALIGN_CHECK_EN
    assign fetch_fault = (bus.fetch_pc >= 32'(MEM_DEPTH)) || (bus.fetch_pc[1:0] != 2'b00);
`else
    assign fetch_fault = (bus.fetch_pc >= 32'(MEM_DEPTH));
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            write_q <= 1'b0;
            fetch_q <= 1'b0;
            fault_q <= 1'b0;
            ir_q    <= 32'h0;
            mdr_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            fetch_q <= fetch_d;
            fault_q <= fault_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        fetch_d       = fetch_q;
        fault_d       = fault_q;
        ir_d          = ir_q;
        mdr_d         = mdr_q;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Data access wins: it belongs to the older instruction.
                if (bus.ls_req) begin
                    addr_d  = bus.ls_addr;
                    wdata_d = bus.ls_wdata;
                    write_d = bus.ls_write;
                    fetch_d = 1'b0;
                    fault_d = ls_fault;
                    wcnt_d  = 4'(WAIT_STATES);
                    state_d = S_ACCESS;
                end else if (bus.fetch_req) begin
                    addr_d  = bus.fetch_pc;
                    wdata_d = 32'h0;
                    write_d = 1'b0;
                    fetch_d = 1'b1;
                    fault_d = fetch_fault;
                    wcnt_d  = 4'(WAIT_STATES);
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    if (write_q)
                        bus.mem_we = ~fault_q;
                    else if (fetch_q)
                        ir_d = fault_q ? 32'h0 : bus.mem_rdata;
                    else
                        mdr_d = fault_q ? 32'h0 : bus.mem_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.fetch_done = (state_q == S_DONE) &&  fetch_q;
    assign bus.ls_done    = (state_q == S_DONE) && !fetch_q;
    assign bus.access_err = (state_q == S_DONE) &&  fault_q;
    assign bus.instr_reg  = ir_q;
    assign bus.load_data  = mdr_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory access controller that sits directly upstream of the unified instruction/data `Memory` and is its only master. It accepts instruction-fetch and load/store requests from the datapath and control unit, and arbitrates between them. It sequences one memory access at a time with a configurable number of wait states. Fetched words are latched into an instruction register (IR) and load data into a memory data register (MDR), so the datapath sees stable values after the memory's combinational read.

## Interface
Parameters:
- `WAIT_STATES`, 1: extra ACCESS cycles before data capture or write strobe; legal range 0–15.
- `MEM_DEPTH`, 513: number of memory words; any address ≥ `MEM_DEPTH` is out of range.

Ports:
- `Clk` input 1: single clock; all state changes on rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `fetch_req` input 1: instruction fetch request; held high until `fetch_done`.
- `fetch_pc` input 32: fetch address, raw memory index.
- `ls_req` input 1: load/store request; held high until `ls_done`.
- `ls_write` input 1: 1 = store, 0 = load.
- `ls_addr` input 32: load/store address.
- `ls_wdata` input 32: store data.
- `fetch_done` output 1: one-cycle pulse; `instr_reg` is valid from this cycle.
- `ls_done` output 1: one-cycle pulse; `load_data` is valid from this cycle (loads only).
- `access_err` output 1: one-cycle pulse with the done pulse on a faulted access.
- `instr_reg` output 32: IR; holds its value until the next fetch completes.
- `load_data` output 32: MDR; holds its value until the next load completes.
- `busy` output 1: high whenever state ≠ IDLE.
- `mem_addr` output 32: to `Memory.Address`.
- `mem_wdata` output 32: to `Memory.writeData`.
- `mem_we` output 1: to `Memory.writeEnable`.
- `mem_rdata` input 32: from `Memory.MemData`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - `ls_req` has priority over `fetch_req`, because a data access belongs to the older instruction.
  - On an accepted request: latch the address, direction and wdata into internal registers; load `wcnt` = `WAIT_STATES`; go to ACCESS.
- ACCESS:
  - `mem_addr` = latched address.
  - If `wcnt` ≠ 0, decrement `wcnt`.
  - If `wcnt` = 0:
    - Load: capture `mem_rdata` into the IR or MDR.
    - Store: assert `mem_we` (combinational from state) for exactly this one cycle.
    - Go to DONE.
- DONE:
  - Pulse the matching done signal (plus `access_err` on a fault).
  - No request is accepted in DONE.
  - Go to IDLE.
- `mem_addr`, `mem_wdata` and `mem_we` are 0 outside ACCESS.
- Requests are sampled only in IDLE; request inputs and their payload are ignored after acceptance. Deasserting a request mid-access does not abort the access.
- Out-of-range address (≥ `MEM_DEPTH`):
  - `mem_we` stays 0.
  - The captured value is 32'h0.
  - `access_err` pulses in DONE.
- Reset (asynchronous, any state):
  - State goes to IDLE; `wcnt` = 0.
  - `instr_reg`, `load_data` = 0.
  - All outputs, including `mem_we`, go to 0 immediately.
  - An interrupted store does not write; the requester must re-issue it.

## Timing
- A request seen high at edge E0 in IDLE → ACCESS occupies the cycles after edges E0 … E0+`WAIT_STATES`.
- Data is captured at edge E0+`WAIT_STATES`+1.
- The done pulse is high in the cycle following that edge.
- Back-to-back throughput: one access per `WAIT_STATES`+3 cycles.
- Simultaneous `fetch_req` and `ls_req`: the load/store completes first. The fetch is accepted in the first IDLE cycle after DONE, provided `fetch_req` is still high.
- `instr_reg` and `load_data` change only at the capture edge.

## Configuration
- Macro `MEM_ALIGN_CHECK_EN`.
- Defined: a fetch with `fetch_pc[1:0]` ≠ 0 is faulted and treated exactly like an out-of-range access: IR = 0, `access_err` pulses with `fetch_done`. Load/store addresses are not checked.
- Undefined: there is no alignment check, and only the `MEM_DEPTH` range check raises `access_err`.

## Test plan
- Reset → all outputs 0 and `busy` = 0. Then fetch with `fetch_pc` = 128 and memory[128] = 32'h8c030000, `WAIT_STATES` = 1 → `fetch_done` in the 3rd cycle after acceptance, `instr_reg` = 32'h8c030000.
- Store `ls_addr` = 6, `ls_wdata` = 32'h15 → `mem_we` high for exactly 1 cycle with `mem_addr` = 6. A subsequent load from 6 → `load_data` = 32'h15 with `ls_done`.
- `fetch_req` and `ls_req` (load from 1, memory[1] = 1) rise on the same edge → `ls_done` first with `load_data` = 1. Then `fetch_done` exactly `WAIT_STATES`+3 cycles later.
- Store to address 600 → `access_err` and `ls_done` pulse together, `mem_we` never asserts, memory is unchanged.
- `Reset_n` pulled low during a store's ACCESS with `WAIT_STATES` = 3 → `mem_we` stays 0, the target word is unchanged, and the FSM returns to IDLE.
- With `MEM_ALIGN_CHECK_EN`: fetch at 130 → `access_err` and `fetch_done` pulse together, `instr_reg` = 0. Without the macro, the same fetch returns memory[130] and no error.
